// File: rtl/mem_store_rmw.sv
// mem_store_rmw: store sequencer with read-modify-write for byte/halfword stores.
// Optional build macro MEM_RMW_MISALIGN_FAULT_EN: reject misaligned H/W stores
// with a fault response and no memory access. Without it, misaligned address
// bits are silently ignored (H uses addr[1] only, W ignores addr[1:0]).

package mem_store_rmw_pkg;
  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] cpu_word;
  typedef enum logic [1:0] {
    MEM_W = 2'd0,
    MEM_H = 2'd1,
    MEM_B = 2'd2
  } mem_mode;
endpackage

// mem_nibble_wr: merge new store data into the old word on the selected lanes.
module mem_nibble_wr
  import mem_store_rmw_pkg::*;
(
  input  cpu_word    old_i,
  input  cpu_word    data_i,
  input  mem_mode    mode_i,
  input  logic [1:0] off_i,
  output cpu_word    merged_o_c
);
  // Lane merge: H picks a half by off[1], B picks a byte by off[1:0], W replaces all.
  always_comb begin
    merged_o_c = old_i;
    case (mode_i)
      MEM_H: begin
        if (off_i[1]) merged_o_c[31:16] = data_i[15:0];
        else          merged_o_c[15:0]  = data_i[15:0];
      end
      MEM_B:   merged_o_c[{off_i, 3'b000} +: 8] = data_i[7:0];
      default: merged_o_c = data_i;
    endcase
  end
endmodule

module mem_store_rmw
  import mem_store_rmw_pkg::*;
#(
  parameter int unsigned ADR_W = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADR_W+1:0] req_addr,
  input  cpu_word          req_wdata,
  input  mem_mode          req_mode,
  output logic             resp_valid,
  output logic             resp_fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADR_W-1:0] mem_adr,
  output cpu_word          mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  cpu_word          mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [ADR_W+1:0] addr_q, addr_d;
  cpu_word          data_q, data_d;
  mem_mode          mode_q, mode_d;
  logic             fault_q, fault_d;
  cpu_word          old_q, old_d;
  cpu_word          merged_c;
  logic             misalign_c;

  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_fault_q, resp_fault_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
  cpu_word          mem_wdata_q, mem_wdata_d;

`ifdef MEM_RMW_MISALIGN_FAULT_EN
  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  assign misalign_c = ((req_mode == MEM_H) && req_addr[0]) ||
                      ((req_mode == MEM_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Merge uses next-state values so the write data is ready in the WR_REQ cycle.
  mem_nibble_wr u_merge (
    .old_i      (old_d),
    .data_i     (data_d),
    .mode_i     (mode_d),
    .off_i      (addr_d[1:0]),
    .merged_o_c (merged_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and request/old-word capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    fault_d = fault_q;
    old_d   = old_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_wdata;
          mode_d  = req_mode;
          fault_d = misalign_c;
          if (misalign_c)              state_d = RESP;
          else if (req_mode == MEM_W)  state_d = WR_REQ;
          else                         state_d = RD_REQ;
        end
      end
      RD_REQ:  if (mem_gnt) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_rvalid) begin
          old_d   = mem_rdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ:  if (mem_gnt) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_adr_d    = '0;
    mem_wdata_d  = '0;
    case (state_d)
      IDLE:   req_ready_d = 1'b1;
      RD_REQ: begin
        mem_req_d = 1'b1;
        mem_adr_d = addr_d[ADR_W+1:2];
      end
      WR_REQ: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_adr_d   = addr_d[ADR_W+1:2];
        mem_wdata_d = (mode_d == MEM_W) ? data_d : merged_c;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        resp_fault_d = fault_d;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      data_q       <= '0;
      mode_q       <= MEM_W;
      fault_q      <= 1'b0;
      old_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_adr_q    <= '0;
      mem_wdata_q  <= '0;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      mode_q       <= mode_d;
      fault_q      <= fault_d;
      old_q        <= old_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_adr_q    <= mem_adr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_adr    = mem_adr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
